// File: rtl/regfile_checker_pkg.sv
// rtl/regfile_checker_pkg.sv - shared state encodings and trace entry layout helpers
// Purpose: common types for regfile_checker and its trace FIFO.
//   state_e        : checker FSM states
//   trace_width    : packed trace entry width {cycle, reg, data}
//   trace_*_lsb    : field offsets inside a packed trace entry
package regfile_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SWEEP = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int TRACE_DATA_LSB = 0;

  function automatic int trace_width(input int cyc_w, input int reg_aw, input int data_w);
    return cyc_w + reg_aw + data_w;
  endfunction

  function automatic int trace_reg_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int trace_cyc_lsb(input int reg_aw, input int data_w);
    return data_w + reg_aw;
  endfunction

endpackage

// File: rtl/regfile_checker_trace_fifo.sv
// rtl/regfile_checker_trace_fifo.sv - synchronous trace FIFO with sticky overflow flag
// Purpose: holds logged regfile writes until the consumer pops them.
// Ports:
//   clock, reset      clock, asynchronous active-low reset
//   clr               synchronous flush (pointers, count, overflow)
//   push, push_data   write request and entry
//   pop               consumer pop request (ignored when empty)
//   head_data         oldest entry, 0 when empty
//   empty, full       occupancy flags
//   ovf               sticky: a push was dropped because the FIFO was full
module regfile_checker_trace_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rp];

  always_ff @(posedge clock) begin
    if (do_push && !clr) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (do_push) begin
        wp <= wp + 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !do_push) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_checker.sv
// rtl/regfile_checker.sv - on-board regfile self-check: run, trace writes, sweep and compare
// Purpose: runs the CPU for num_cycles, logs regfile writes, then sweeps every register
//   through a hijacked read port and compares it with an expected-value ROM.
// Build option: CHECKER_TRACE_EN builds the trace FIFO; otherwise trace_* outputs are tied 0.
// Ports:
//   clock, reset             clock, asynchronous active-low reset
//   start, num_cycles        begin run (IDLE/DONE only), run length sampled on start
//   wr_en, wr_reg, wr_data   snooped regfile write port
//   test_mode, test_reg      read-port hijack select and sweep index
//   test_data                regfile read data (combinational)
//   exp_addr, exp_data       expected ROM address / data (1-cycle latency)
//   trace_valid/ready        trace FIFO head handshake
//   trace_cycle/reg/data     head entry fields
//   trace_ovf                sticky dropped-write flag
//   busy, done, pass         status
//   err_count, first_err     saturating mismatch count, index of first mismatch
module regfile_checker
  import regfile_checker_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int REG_AW      = 5,
  parameter int DATA_W      = 32,
  parameter int CYC_W       = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  output logic              test_mode,
  output logic [REG_AW-1:0] test_reg,
  input  logic [DATA_W-1:0] test_data,
  output logic [REG_AW-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [CYC_W-1:0]  trace_cycle,
  output logic [REG_AW-1:0] trace_reg,
  output logic [DATA_W-1:0] trace_data,
  output logic              trace_ovf,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [REG_AW:0]   err_count,
  output logic [REG_AW-1:0] first_err
);

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  state_e            state;
  state_e            state_next;
  logic [CYC_W-1:0]  cyc;
  logic [CYC_W-1:0]  ncyc;
  logic [REG_AW-1:0] idx;
  logic [REG_AW-1:0] cmp_idx;
  logic [DATA_W-1:0] test_q;
  logic              cmp_valid;
  logic [REG_AW:0]   err_q;
  logic [REG_AW-1:0] first_q;
  logic              start_ok;
  logic              run_last;
  logic              log_push;
  logic              mismatch;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  // num_cycles==0 still spends one cycle in RUN, so it is treated as the last cycle.
  assign run_last  = (ncyc == '0) || (cyc == ncyc - 1'b1);
  assign log_push  = (state == ST_RUN) && (ncyc != '0) && wr_en && (wr_reg != '0);
  // test_q holds the register sampled last cycle; the ROM word for that index arrives now.
  assign mismatch  = cmp_valid && (test_q != exp_data);
  assign err_count = err_q;
  assign first_err = first_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    test_mode  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    test_reg   = '0;
    exp_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (run_last) state_next = ST_SWEEP;
      end
      ST_SWEEP: begin
        busy      = 1'b1;
        test_mode = 1'b1;
        test_reg  = idx;
        exp_addr  = idx;
        if (idx == LAST_IDX) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        test_mode  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
    pass = done && (err_q == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc       <= '0;
      ncyc      <= '0;
      idx       <= '0;
      cmp_idx   <= '0;
      test_q    <= '0;
      cmp_valid <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else if (start_ok) begin
      cyc       <= '0;
      ncyc      <= num_cycles;
      idx       <= '0;
      cmp_valid <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
    end else begin
      cmp_valid <= (state == ST_SWEEP);
      if (state == ST_RUN) begin
        cyc <= cyc + 1'b1;
      end
      if (state == ST_SWEEP) begin
        test_q  <= test_data;
        cmp_idx <= idx;
        idx     <= idx + 1'b1;
      end
      if (mismatch) begin
        // err_q is still 0 only until the first mismatch, and saturation never returns it to 0.
        if (err_q == '0) first_q <= cmp_idx;
        if (err_q != '1) err_q <= err_q + 1'b1;
      end
    end
  end

`ifdef CHECKER_TRACE_EN
  localparam int TW      = trace_width(CYC_W, REG_AW, DATA_W);
  localparam int REG_LSB = trace_reg_lsb(DATA_W);
  localparam int CYC_LSB = trace_cyc_lsb(REG_AW, DATA_W);

  logic [TW-1:0] push_entry;
  logic [TW-1:0] head_entry;
  logic          fifo_empty;
  logic          unused_fifo_full;

  assign push_entry = {cyc, wr_reg, wr_data};

  regfile_checker_trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .clr       (start_ok),
    .push      (log_push),
    .push_data (push_entry),
    .pop       (trace_ready),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (unused_fifo_full),
    .ovf       (trace_ovf)
  );

  assign trace_valid = !fifo_empty;
  assign trace_data  = head_entry[TRACE_DATA_LSB +: DATA_W];
  assign trace_reg   = head_entry[REG_LSB +: REG_AW];
  assign trace_cycle = head_entry[CYC_LSB +: CYC_W];
`else
  logic unused_trace;

  assign unused_trace = ^{trace_ready, log_push, wr_data};
  assign trace_valid  = 1'b0;
  assign trace_cycle  = '0;
  assign trace_reg    = '0;
  assign trace_data   = '0;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// tb/tb_regfile_checker.sv - scoreboard bench for regfile_checker
module tb_regfile_checker;

`ifdef CHECKER_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_cycles = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_reg = '0;
  logic [31:0] wr_data = '0;
  logic        test_mode;
  logic [4:0]  test_reg;
  logic [31:0] test_data;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        trace_valid;
  logic        trace_ready = 1'b1;
  logic [15:0] trace_cycle;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic        trace_ovf;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_count;
  logic [4:0]  first_err;

  logic [31:0] regs [32];
  logic [31:0] rom  [32];

  typedef struct packed { logic [5:0] err; logic [4:0] first; logic pass; } res_t;
  typedef struct packed { logic [15:0] c; logic [4:0] r; logic [31:0] d; } tr_t;
  res_t rq[$];
  tr_t  tq[$];

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  int pops = 0;
  int p0 = 0;
  logic done_q = 1'b0;
  res_t mr;
  tr_t  mt;

  regfile_checker #(.TRACE_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_cycles  (num_cycles),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .test_mode   (test_mode),
    .test_reg    (test_reg),
    .test_data   (test_data),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_cycle (trace_cycle),
    .trace_reg   (trace_reg),
    .trace_data  (trace_data),
    .trace_ovf   (trace_ovf),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .first_err   (first_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clock) exp_data <= rom[exp_addr];
  assign test_data = regs[test_reg];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_cycles = n;
    step();
    start = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int g = 0;
    while (!done && g < 300) begin
      step();
      g++;
    end
    chk(name, 64'(cyc_cnt - t0), 64'(exp_lat));
  endtask

  // Monitor: results are checked when done rises, trace entries on every pop handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (done && !done_q) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no result");
        end else begin
          mr = rq.pop_front();
          chk("err_count", 64'(err_count), 64'(mr.err));
          chk("first_err", 64'(first_err), 64'(mr.first));
          chk("pass", 64'(pass), 64'(mr.pass));
        end
      end
      if (trace_valid && trace_ready) begin
        pops++;
        if (tq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trace: got reg=%0d data=%0h expected none", trace_reg, trace_data);
        end else begin
          mt = tq.pop_front();
          chk("trace_cycle", 64'(trace_cycle), 64'(mt.c));
          chk("trace_reg", 64'(trace_reg), 64'(mt.r));
          chk("trace_data", 64'(trace_data), 64'(mt.d));
        end
      end
    end
    done_q = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h11;
      rom[i]  = regs[i];
    end

    // Reset state
    step();
    step();
    chk("rst_test_mode", 64'(test_mode), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_first_err", 64'(first_err), 0);
    chk("rst_trace_valid", 64'(trace_valid), 0);
    chk("rst_trace_ovf", 64'(trace_ovf), 0);
    chk("rst_test_reg", 64'(test_reg), 0);
    reset = 1'b1;
    step();

    // 1: five cycles, r3 write logged, r0 write dropped, clean sweep
    regs[3] = 32'd7;
    rom[3]  = 32'd7;
    if (TR) tq.push_back('{c: 16'd1, r: 5'd3, d: 32'd7});
    rq.push_back('{err: 6'd0, first: 5'd0, pass: 1'b1});
    do_start(16'd5);
    chk("t1_busy", 64'(busy), 1);
    step();
    wr_en = 1'b1; wr_reg = 5'd3; wr_data = 32'd7;
    step();
    wr_reg = 5'd0; wr_data = 32'd9;
    step();
    wr_en = 1'b0;
    wait_done(38, "t1_latency");
    chk("t1_test_mode_done", 64'(test_mode), 0);

    // 2: two mismatches, r4 first
    rom[4]  = 32'd10;
    regs[4] = 32'd11;
    regs[9] = regs[9] ^ 32'h100;
    rq.push_back('{err: 6'd2, first: 5'd4, pass: 1'b0});
    do_start(16'd3);
    wait_done(36, "t2_latency");
    rom[4]  = 32'h1000_0044;
    regs[4] = 32'h1000_0044;
    regs[9] = rom[9];

    // 3: overflow with ready low, then push+pop at full
    trace_ready = 1'b0;
    p0 = pops;
    rq.push_back('{err: 6'd0, first: 5'd0, pass: 1'b1});
    do_start(16'd8);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_reg = 5'(i + 1); wr_data = 32'(100 + i);
      if (TR && i < 4) tq.push_back('{c: 16'(i), r: 5'(i + 1), d: 32'(100 + i)});
      step();
    end
    wr_reg = 5'd7; wr_data = 32'd107; trace_ready = 1'b1;
    if (TR) tq.push_back('{c: 16'd6, r: 5'd7, d: 32'd107});
    step();
    wr_en = 1'b0; trace_ready = 1'b0;
    wait_done(41, "t3_latency");
    chk("t3_ovf", 64'(trace_ovf), 64'(TR));
    chk("t3_valid_held", 64'(trace_valid), 64'(TR));
    trace_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t3_pops", 64'(pops - p0), TR ? 64'd5 : 64'd0);
    chk("t3_valid_drained", 64'(trace_valid), 0);

    // 4: zero-length run, write during the single RUN cycle is not logged
    p0 = pops;
    rq.push_back('{err: 6'd0, first: 5'd0, pass: 1'b1});
    do_start(16'd0);
    wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hdead;
    step();
    wr_en = 1'b0;
    wait_done(34, "t4_latency");
    chk("t4_trace_valid", 64'(trace_valid), 0);
    chk("t4_pops", 64'(pops - p0), 0);

    // 6: start during RUN ignored; start in DONE clears errors and overflow
    trace_ready = 1'b0;
    regs[7] = regs[7] ^ 32'h1;
    rq.push_back('{err: 6'd1, first: 5'd7, pass: 1'b0});
    do_start(16'd6);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_reg = 5'(i + 1); wr_data = 32'(200 + i);
      start = (i == 2);
      num_cycles = (i == 2) ? 16'd20 : 16'd6;
      step();
    end
    wr_en = 1'b0; start = 1'b0;
    wait_done(39, "t6_latency");
    chk("t6_ovf_set", 64'(trace_ovf), 64'(TR));
    regs[7] = rom[7];
    rq.push_back('{err: 6'd0, first: 5'd0, pass: 1'b1});
    do_start(16'd2);
    chk("t6_err_cleared", 64'(err_count), 0);
    chk("t6_ovf_cleared", 64'(trace_ovf), 0);
    chk("t6_fifo_cleared", 64'(trace_valid), 0);
    chk("t6_done_dropped", 64'(done), 0);
    wait_done(35, "t6b_latency");
    trace_ready = 1'b1;

    // 5: reset during sweep at idx 10
    regs[2] = regs[2] ^ 32'h8000_0000;
    do_start(16'd1);
    begin
      int g = 0;
      while (test_reg != 5'd10 && g < 100) begin
        step();
        g++;
      end
    end
    chk("t5_idx", 64'(test_reg), 10);
    chk("t5_test_mode_sweep", 64'(test_mode), 1);
    chk("t5_err_before_reset", 64'(err_count), 1);
    reset = 1'b0;
    #1;
    chk("t5_test_mode_rst", 64'(test_mode), 0);
    chk("t5_busy_rst", 64'(busy), 0);
    chk("t5_err_rst", 64'(err_count), 0);
    chk("t5_test_reg_rst", 64'(test_reg), 0);
    step();
    reset = 1'b1;
    regs[2] = rom[2];
    rq.push_back('{err: 6'd0, first: 5'd0, pass: 1'b1});
    do_start(16'd1);
    wait_done(34, "t5_rerun_latency");

    for (int i = 0; i < 4; i++) step();
    chk("end_result_queue", 64'(rq.size()), 0);
    chk("end_trace_queue", 64'(tq.size()), 0);
    chk("end_trace_valid", 64'(trace_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
